// File: rtl/register_dump_sequencer.sv
// Streams registers FIRST_REG..FIRST_REG+NUM_REGS-1 MSB-first as 4 bytes each over a valid/ready byte port.
// First byte offered two edges after start, one LOAD bubble per register; SEND stalls while byteReady is low.
module register_dump_sequencer #(
    parameter int NUM_REGS  = 32,
    parameter int FIRST_REG = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] regValue,
    input  logic        byteReady,
    output logic [4:0]  addrAsync,
    output logic [7:0]  byteOut,
    output logic        byteValid,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
    localparam logic [4:0] LAST_ADDR  = 5'(FIRST_REG + NUM_REGS - 1);

    logic [1:0]  state;
    logic [31:0] shift_reg;
    logic [1:0]  byte_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addrAsync <= 5'd0;
            shift_reg <= 32'd0;
            byte_cnt  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    // abort is deliberately not looked at here, so start always wins
                    if (start) begin
                        addrAsync <= FIRST_ADDR;
                        byte_cnt  <= 2'd0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        shift_reg <= regValue;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (byteReady) begin
                        if (byte_cnt != 2'd3) begin
                            shift_reg <= {shift_reg[23:0], 8'h00};
                            byte_cnt  <= byte_cnt + 2'd1;
                        end else if (addrAsync == LAST_ADDR) begin
                            state <= DONE;
                        end else begin
                            addrAsync <= addrAsync + 5'd1;
                            byte_cnt  <= 2'd0;
                            state     <= LOAD;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Every output is decoded from registered state, so reset clears them without waiting for a clock.
    assign byteOut   = shift_reg[31:24];
    assign byteValid = (state == SEND);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_register_dump_sequencer.sv
// Bench for register_dump_sequencer: three parameterisations share a clock and reset;
// expected bytes are queued from a bank model at start and popped on each handshake.
module tb_register_dump_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             reset;
    logic [2:0]       start_v;
    logic [2:0]       abort_v;
    logic [2:0]       byte_ready;
    logic [2:0][31:0] reg_value;
    logic [2:0][4:0]  addr;
    logic [2:0][7:0]  byte_out;
    logic [2:0]       byte_valid;
    logic [2:0]       busy_v;
    logic [2:0]       done_v;

    logic [31:0] bank [3][32];

    assign reg_value[0] = bank[0][addr[0]];
    assign reg_value[1] = bank[1][addr[1]];
    assign reg_value[2] = bank[2][addr[2]];

    register_dump_sequencer #(.NUM_REGS(32), .FIRST_REG(0)) dut_full (
        .clock(clock), .reset(reset), .start(start_v[0]), .abort(abort_v[0]),
        .regValue(reg_value[0]), .byteReady(byte_ready[0]), .addrAsync(addr[0]),
        .byteOut(byte_out[0]), .byteValid(byte_valid[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    register_dump_sequencer #(.NUM_REGS(1), .FIRST_REG(0)) dut_one (
        .clock(clock), .reset(reset), .start(start_v[1]), .abort(abort_v[1]),
        .regValue(reg_value[1]), .byteReady(byte_ready[1]), .addrAsync(addr[1]),
        .byteOut(byte_out[1]), .byteValid(byte_valid[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    register_dump_sequencer #(.NUM_REGS(4), .FIRST_REG(28)) dut_top (
        .clock(clock), .reset(reset), .start(start_v[2]), .abort(abort_v[2]),
        .regValue(reg_value[2]), .byteReady(byte_ready[2]), .addrAsync(addr[2]),
        .byteOut(byte_out[2]), .byteValid(byte_valid[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    int         tests = 0;
    int         fails = 0;
    int         xfer  = 0;
    bit         hold_pend = 1'b0;
    logic [7:0] held_byte = 8'h00;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int d, input int first, input int n);
        logic [31:0] w;
        for (int r = first; r < first + n; r++) begin
            w = bank[d][r];
            for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
        end
    endtask

    // Called with inputs settled for the coming edge; scores a handshake, then advances one clock.
    task automatic step(input int d);
        logic [7:0] exp_b;
        if (hold_pend) begin
            check("hold_valid", 32'(byte_valid[d]), 32'd1);
            check("hold_byte", 32'(byte_out[d]), 32'(held_byte));
        end
        hold_pend = byte_valid[d] && !byte_ready[d] && !abort_v[d];
        held_byte = byte_out[d];
        if (byte_valid[d] && byte_ready[d] && !abort_v[d]) begin
            xfer++;
            if (exp_q.size() == 0) begin
                check("byte_extra", 32'(xfer), 32'd0);
            end else begin
                exp_b = exp_q.pop_front();
                check("byte", 32'(byte_out[d]), 32'(exp_b));
            end
        end
        @(posedge clock);
        #1;
    endtask

    // mode: 0 ready tied high, 1 ready toggles, 2 ready random
    task automatic run_dump(input int d, input int first, input int n, input int mode,
                            input int abort_at, input bit keep_start,
                            input bit abort_with_start, input bit rewrite);
        int cyc      = 0;
        int loads    = 0;
        int dones    = 0;
        int max_addr = 0;
        bit aborting = 1'b0;
        exp_q.delete();
        push_exp(d, first, n);
        xfer      = 0;
        hold_pend = 1'b0;
        start_v[d] = 1'b1;
        abort_v[d] = abort_with_start;
        step(d);
        abort_v[d] = 1'b0;
        if (!keep_start) start_v[d] = 1'b0;
        check("busy_after_start", 32'(busy_v[d]), 32'd1);
        check("valid_in_load", 32'(byte_valid[d]), 32'd0);
        while (busy_v[d] && cyc < 1000) begin
            if (cyc == 1) check("first_valid", 32'(byte_valid[d]), 32'd1);
            if (!byte_valid[d] && !done_v[d]) loads++;
            if (done_v[d]) begin
                dones++;
                check("done_after_last", 32'(xfer), 32'(4 * n));
                start_v[d] = 1'b0;
            end
            if (int'(addr[d]) > max_addr) max_addr = int'(addr[d]);
            case (mode)
                0:       byte_ready[d] = 1'b1;
                1:       byte_ready[d] = (cyc % 2) == 1;
                default: byte_ready[d] = ($urandom_range(0, 3) != 0);
            endcase
            if (abort_at >= 0 && xfer == abort_at && !aborting) begin
                abort_v[d] = 1'b1;
                aborting   = 1'b1;
            end
            if (rewrite && byte_valid[d] && (xfer % 4) == 1) bank[d][addr[d]] = 32'h5A5A_5A5A;
            step(d);
            if (abort_v[d]) begin
                check("abort_busy", 32'(busy_v[d]), 32'd0);
                check("abort_valid", 32'(byte_valid[d]), 32'd0);
            end
            abort_v[d] = 1'b0;
            cyc++;
        end
        if (cyc >= 1000) check("timeout", 32'd0, 32'd1);
        if (abort_at >= 0) begin
            check("abort_xfers", 32'(xfer), 32'(abort_at));
            check("abort_no_done", 32'(dones), 32'd0);
            exp_q.delete();
        end else begin
            check("xfers", 32'(xfer), 32'(4 * n));
            check("done_pulses", 32'(dones), 32'd1);
            check("load_cycles", 32'(loads), 32'(n));
            check("left_in_queue", 32'(exp_q.size()), 32'd0);
            check("max_addr", 32'(max_addr), 32'(first + n - 1));
            if (mode == 0) check("dump_cycles", 32'(cyc), 32'(5 * n + 1));
        end
        check("busy_end", 32'(busy_v[d]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(d);
            check("stays_idle", 32'(busy_v[d]), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int guard;
        reset      = 1'b0;
        start_v    = '0;
        abort_v    = '0;
        byte_ready = '0;
        for (int i = 0; i < 32; i++) begin
            bank[0][i] = 32'h100 + 32'(i);
            bank[1][i] = 32'h0;
            bank[2][i] = $urandom;
        end
        bank[1][0] = 32'hDEAD_BEEF;

        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy_v), 32'd0);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_done", 32'(done_v), 32'd0);
        check("rst_addr", 32'(addr[0]), 32'd0);
        check("rst_byte", 32'(byte_out[0]), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0);
            check("idle_after_reset", 32'(busy_v[0]), 32'd0);
        end

        run_dump(0, 0, 32, 0, -1, 1'b0, 1'b0, 1'b0);
        run_dump(1, 0, 1, 1, -1, 1'b0, 1'b0, 1'b0);

        abort_v[1] = 1'b1;
        step(1);
        check("abort_in_idle", 32'(busy_v[1]), 32'd0);
        abort_v[1] = 1'b0;
        run_dump(1, 0, 1, 1, -1, 1'b0, 1'b1, 1'b0);

        run_dump(2, 28, 4, 2, -1, 1'b1, 1'b0, 1'b0);
        run_dump(0, 0, 32, 0, 6, 1'b0, 1'b0, 1'b0);
        run_dump(0, 0, 32, 2, -1, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset landing mid-SEND, away from any clock edge.
        exp_q.delete();
        push_exp(0, 0, 32);
        xfer          = 0;
        hold_pend     = 1'b0;
        byte_ready[0] = 1'b1;
        start_v[0]    = 1'b1;
        step(0);
        start_v[0] = 1'b0;
        guard = 0;
        while (!(byte_valid[0] && addr[0] == 5'd2) && guard < 50) begin
            step(0);
            guard++;
        end
        check("reach_send", 32'(byte_valid[0]), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(byte_valid[0]), 32'd0);
        check("async_rst_busy", 32'(busy_v[0]), 32'd0);
        check("async_rst_addr", 32'(addr[0]), 32'd0);
        check("async_rst_byte", 32'(byte_out[0]), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        hold_pend = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0);
            check("no_dump_after_reset", 32'(busy_v[0]), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/register_dump_sequencer.md
REGISTER_DUMP_SEQUENCER -- requirements
Module: register_dump_sequencer

Interface
REQ-001 Parameter NUM_REGS, default 32, number of registers dumped, legal range 1..32.
REQ-002 Parameter FIRST_REG, default 0, first register index dumped; FIRST_REG+NUM_REGS SHALL NOT exceed 32.
REQ-003 clock  input  1  single clock for all state; all sequential logic updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, independent of clock.
REQ-005 start  input  1  request to begin a dump; sampled only in IDLE.
REQ-006 abort  input  1  cancel the dump in progress.
REQ-007 regValue  input  32  asynchronous read data from the register bank for index addrAsync.
REQ-008 byteReady  input  1  downstream (UART transmitter) can accept a byte this cycle.
REQ-009 addrAsync  output  5  register index driven to the register bank asynchronous read port.
REQ-010 byteOut  output  8  byte being offered downstream.
REQ-011 byteValid  output  1  byteOut is valid; transfer occurs on a rising edge with byteValid=1 and byteReady=1.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the last byte of the last register has transferred.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, SEND, DONE; all outputs registered or decoded from registered state only.
REQ-015 IDLE: start=1 at an edge -> addrAsync<=FIRST_REG, byteCnt<=0, state LOAD; start=0 -> remain IDLE.
REQ-016 LOAD: one cycle; at the next edge shiftReg<=regValue, state SEND (regValue is stable because addrAsync was set one edge earlier).
REQ-017 SEND: byteValid=1, byteOut=shiftReg[31:24] (MSB first).
REQ-018 SEND with byteReady=0: hold byteOut, byteValid, shiftReg, byteCnt unchanged.
REQ-019 SEND with byteReady=1 and byteCnt<3: shiftReg<=shiftReg<<8, byteCnt<=byteCnt+1, stay SEND.
REQ-020 SEND with byteReady=1 and byteCnt=3: if addrAsync=FIRST_REG+NUM_REGS-1 -> state DONE; else addrAsync<=addrAsync+1, byteCnt<=0, state LOAD.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; addrAsync holds last index.
REQ-022 Total bytes per dump SHALL equal 4*NUM_REGS; addrAsync SHALL never exceed FIRST_REG+NUM_REGS-1 (no 5-bit wrap).
REQ-023 Latency: start sampled at edge N -> busy=1 after N, first byteValid=1 after N+1; between registers exactly one LOAD cycle with byteValid=0.
REQ-024 start while busy=1 SHALL be ignored; no restart, no queuing.
REQ-025 abort=1 in LOAD, SEND or DONE -> next edge state IDLE, byteValid=0, done not pulsed; abort has priority over byteReady at the same edge (byte counts as not transferred).
REQ-026 abort in IDLE SHALL be ignored; abort and start both high in IDLE -> start wins.
REQ-027 The block SHALL never write the register bank; it drives only the asynchronous read address.

Reset
REQ-028 reset=0 SHALL immediately force state IDLE, addrAsync=0, byteOut=0, byteValid=0, busy=0, done=0, shiftReg=0, byteCnt=0, including mid-dump.
REQ-029 After reset release, the first dump SHALL start only on a new start in IDLE.

Verification
REQ-030 Full dump, byteReady tied 1, regs r[i]=i+0x100: start pulse -> 128 bytes 00 00 01 00, 00 00 01 01, ... 00 00 01 1F; done one cycle after last byte; busy low next.
REQ-031 Backpressure: r0=0xDEADBEEF, NUM_REGS=1, byteReady toggles 1/0 -> bytes DE AD BE EF each held stable while byteReady=0, exactly 4 transfers.
REQ-032 Abort: assert abort after 6th byte transferred -> byteValid=0 and busy=0 next cycle, done never asserted; subsequent start restarts at FIRST_REG with byte 0.
REQ-033 Reset mid-dump: reset=0 asynchronously during SEND (no clock edge) -> byteValid, busy, addrAsync go 0 immediately.
REQ-034 start asserted continuously during dump -> only one dump of 4*NUM_REGS bytes per start edge in IDLE; FIRST_REG=28, NUM_REGS=4 -> addrAsync 28..31, never wraps to 0.
REQ-035 Register value changed by bank write during SEND -> bytes of current register unchanged (captured in LOAD).
